// File: rtl/agg_acc_array_if.sv
// Beat/result handshake bundle for the per-channel group accumulator.
// The master drives beats and out_ready; the slave returns results.
interface agg_acc_array_if #(
    parameter int N     = 12,
    parameter int CH    = 4,
    parameter int LEN_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [CH*N-1:0]   in_data;
    logic [LEN_W-1:0]  len;
    logic              act_en;
    logic              out_valid;
    logic              out_ready;
    logic [CH*N-1:0]   out_data;
    logic [CH-1:0]     out_sat;

    modport master (
        output in_valid, in_data, len, act_en, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, len, act_en, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/agg_acc_array.sv
// Multi-channel group accumulator: sums len+1 signed beats per channel, then
// presents a saturated (optionally ReLU-clamped) result held under backpressure.
module agg_acc_array #(
    parameter int N     = 12,
    parameter int CH    = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    agg_acc_array_if.slave   bus
);
    localparam int ACC_W = N + LEN_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(LEN_W+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(LEN_W+1){1'b1}}, {(N-1){1'b0}}};

    logic [1:0]               state_r;
    logic [LEN_W-1:0]         cnt_r;
    logic [LEN_W-1:0]         len_r;
    logic                     act_en_r;
    logic signed [ACC_W-1:0]  acc_r [CH];
    logic [CH*N-1:0]          out_data_r;
    logic [CH-1:0]            out_sat_r;
    logic                     out_valid_r;
    logic                     in_ready_r;

    logic                     accept_s;
    logic                     relu_s;
    logic                     last_s;
    logic [LEN_W-1:0]         cnt_inc_s;
    logic signed [ACC_W-1:0]  ext_s [CH];
    logic signed [ACC_W-1:0]  sum_s [CH];
    logic [CH*N-1:0]          res_data_s;
    logic [CH-1:0]            res_sat_s;

    // Returns {sat_flag, data}; a negative sum with ReLU on is zero, never a clip.
    function automatic logic [N:0] sat_relu(input logic signed [ACC_W-1:0] a,
                                            input logic relu);
        logic [N:0] r;
        if (relu && a[ACC_W-1]) begin
            r = {1'b0, {N{1'b0}}};
        end else if (a > SAT_MAX) begin
            r = {1'b1, SAT_MAX[N-1:0]};
        end else if (a < SAT_MIN) begin
            r = {1'b1, SAT_MIN[N-1:0]};
        end else begin
            r = {1'b0, a[N-1:0]};
        end
        return r;
    endfunction

    assign accept_s  = bus.in_valid & in_ready_r;
    assign cnt_inc_s = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};

    // Next accumulator value and the result it would produce if this beat ends the group.
    always_comb begin
        res_data_s = {(CH*N){1'b0}};
        res_sat_s  = {CH{1'b0}};
        if (state_r == ST_IDLE) begin
            relu_s = bus.act_en;
            last_s = (bus.len == {LEN_W{1'b0}});
        end else begin
            relu_s = act_en_r;
            last_s = (cnt_inc_s == len_r);
        end
        for (int k = 0; k < CH; k++) begin
            ext_s[k] = {{LEN_W{bus.in_data[k*N+N-1]}}, bus.in_data[k*N +: N]};
            if (state_r == ST_IDLE) begin
                sum_s[k] = ext_s[k];
            end else begin
                sum_s[k] = acc_r[k] + ext_s[k];
            end
            {res_sat_s[k], res_data_s[k*N +: N]} = sat_relu(sum_s[k], relu_s);
        end
    end

    // Group FSM; result registers are loaded on the final beat so they are stable in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {LEN_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            act_en_r    <= 1'b0;
            out_data_r  <= {(CH*N){1'b0}};
            out_sat_r   <= {CH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            for (int k = 0; k < CH; k++) acc_r[k] <= {ACC_W{1'b0}};
        end else if (clear) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {LEN_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            act_en_r    <= 1'b0;
            out_data_r  <= {(CH*N){1'b0}};
            out_sat_r   <= {CH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            for (int k = 0; k < CH; k++) acc_r[k] <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_ACC: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        if (state_r == ST_IDLE) begin
                            cnt_r    <= {LEN_W{1'b0}};
                            len_r    <= bus.len;
                            act_en_r <= bus.act_en;
                        end else begin
                            cnt_r    <= cnt_inc_s;
                        end
                        if (last_s) begin
                            state_r     <= ST_OUT;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            out_data_r  <= res_data_s;
                            out_sat_r   <= res_sat_s;
                        end else begin
                            state_r     <= ST_ACC;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_data_r  <= {(CH*N){1'b0}};
                        out_sat_r   <= {CH{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_data_r  <= {(CH*N){1'b0}};
                    out_sat_r   <= {CH{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
endmodule

// File: tb/tb_agg_acc_array.sv
// Directed bench for agg_acc_array with a term-counting group model checked every cycle.
module tb_agg_acc_array;
    localparam int N     = 12;
    localparam int CH    = 4;
    localparam int LEN_W = 4;
    localparam int MAXV  = (1 << (N-1)) - 1;
    localparam int MINV  = -(1 << (N-1));

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    agg_acc_array_if #(.N(N), .CH(CH), .LEN_W(LEN_W)) bus ();

    agg_acc_array #(.N(N), .CH(CH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a group is "terms left to collect" plus plain integer sums per channel.
    int m_sum [CH];
    int m_left;
    bit m_coll;
    bit m_out;
    bit m_relu;

    function automatic int smp(input logic [CH*N-1:0] d, input int k);
        logic [N-1:0] v;
        v = d[k*N +: N];
        return {{(32-N){v[N-1]}}, v};
    endfunction

    function automatic logic [N-1:0] m_data(input int s, input bit r);
        int v;
        v = s;
        if (r && s < 0) v = 0;
        else if (s > MAXV) v = MAXV;
        else if (s < MINV) v = MINV;
        return v[N-1:0];
    endfunction

    function automatic bit m_satf(input int s, input bit r);
        return !(r && s < 0) && (s > MAXV || s < MINV);
    endfunction

    function automatic logic [CH*N-1:0] exp_data();
        logic [CH*N-1:0] d;
        d = '0;
        for (int k = 0; k < CH; k++) if (m_out) d[k*N +: N] = m_data(m_sum[k], m_relu);
        return d;
    endfunction

    function automatic logic [CH-1:0] exp_sat();
        logic [CH-1:0] s;
        s = '0;
        for (int k = 0; k < CH; k++) if (m_out) s[k] = m_satf(m_sum[k], m_relu);
        return s;
    endfunction

    function automatic logic [CH*N-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {N'(c3), N'(c2), N'(c1), N'(c0)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_out  <= 1'b0;
            m_coll <= 1'b0;
            m_left <= 0;
            m_relu <= 1'b0;
            for (int k = 0; k < CH; k++) m_sum[k] <= 0;
        end else if (m_out) begin
            if (bus.out_ready) m_out <= 1'b0;
        end else if (bus.in_valid) begin
            if (!m_coll) begin
                for (int k = 0; k < CH; k++) m_sum[k] <= smp(bus.in_data, k);
                m_relu <= bus.act_en;
                m_left <= int'(bus.len);
                if (bus.len == 0) m_out <= 1'b1;
                else m_coll <= 1'b1;
            end else begin
                for (int k = 0; k < CH; k++) m_sum[k] <= m_sum[k] + smp(bus.in_data, k);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_out  <= 1'b1;
                    m_coll <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, want, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_valid", 64'(bus.out_valid), 64'(m_out));
            chk("cyc_ready", 64'(bus.in_ready), 64'(!m_out));
            chk("cyc_data",  64'(bus.out_data), 64'(exp_data()));
            chk("cyc_sat",   64'(bus.out_sat),  64'(exp_sat()));
        end
    end

    task automatic beat(input logic [CH*N-1:0] d, input int l, input bit a);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.len      = LEN_W'(l);
        bus.act_en   = a;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = pack(1234, -999, 77, -1);
    endtask

    // Result must be present right after the final beat; then let OUT drain.
    task automatic expect_out(input string nm, input logic [CH*N-1:0] d, input logic [CH-1:0] s);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_data"},  64'(bus.out_data),  64'(d));
        chk({nm, "_sat"},   64'(bus.out_sat),   64'(s));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.len       = '0;
        bus.act_en    = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready),  64'd1);
        chk("rst_data",  64'(bus.out_data),  64'd0);
        chk("rst_sat",   64'(bus.out_sat),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        beat(pack(100, 0, 0, 0), 2, 1'b0);
        beat(pack(200, 0, 0, 0), 2, 1'b0);
        beat(pack(-50, 0, 0, 0), 2, 1'b0);
        expect_out("sum3", pack(250, 0, 0, 0), 4'b0000);

        beat(pack(0, -10, 300, 0), 1, 1'b1);
        @(posedge clk); #1;
        beat(pack(0, -20, 200, 0), 7, 1'b0);
        expect_out("relu", pack(0, 0, 500, 0), 4'b0000);

        for (int i = 0; i < 16; i++) beat(pack(2047, 1, 0, -2048), 15, 1'b0);
        expect_out("sat16", pack(2047, 16, 0, -2048), 4'b1001);

        for (int i = 0; i < 16; i++) beat(pack(2047, -1, 0, -2048), 15, 1'b1);
        expect_out("satrelu", pack(2047, 0, 0, 0), 4'b0001);

        bus.out_ready = 1'b0;
        beat(pack(5, 0, 0, 0), 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pack(99, 99, 99, 99);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready),  64'd0);
            chk("hold_data",  64'(bus.out_data),  64'(pack(5, 0, 0, 0)));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("hold_last", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        chk("rel_valid", 64'(bus.out_valid), 64'd0);
        chk("rel_ready", 64'(bus.in_ready),  64'd1);

        beat(pack(1000, 3, 0, 0), 3, 1'b0);
        beat(pack(1000, 3, 0, 0), 3, 1'b0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pack(500, 0, 0, 0);
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_valid", 64'(bus.out_valid), 64'd0);
        beat(pack(7, 0, 0, 0), 0, 1'b0);
        expect_out("postclr", pack(7, 0, 0, 0), 4'b0000);

        bus.out_ready = 1'b0;
        beat(pack(-3, 0, 0, 0), 0, 1'b0);
        chk("pre_rst", 64'(bus.out_data), 64'(pack(-3, 0, 0, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_data",  64'(bus.out_data),  64'd0);
        chk("async_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        beat(pack(10, 0, 0, 0), 1, 1'b0);
        beat(pack(20, 0, 0, 0), 1, 1'b0);
        expect_out("postrst", pack(30, 0, 0, 0), 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/agg_acc_array.md
AGG_ACC_ARRAY -- requirements
Module: agg_acc_array

Interface
- REQ-001: The module SHALL have parameter N, default 12, giving the signed data width per channel.
- REQ-002: The module SHALL have parameter CH, default 4, giving the number of parallel channels.
- REQ-003: The module SHALL have parameter LEN_W, default 4, giving the width of the term-count field; internal accumulator width ACC_W = N+LEN_W.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous and active-low.
- REQ-006: clear  input  1  synchronous abort; discards the current group.
- REQ-007: in_valid  input  1  input beat valid.
- REQ-008: in_ready  output  1  block accepts a beat.
- REQ-009: in_data  input  CH*N  signed channel samples; channel k at bits [k*N +: N].
- REQ-010: len  input  LEN_W  terms per group minus 1; sampled on the first beat of a group.
- REQ-011: act_en  input  1  ReLU enable; sampled on the first beat of a group.
- REQ-012: out_valid  output  1  result valid.
- REQ-013: out_ready  input  1  downstream accepts result.
- REQ-014: out_data  output  CH*N  signed per-channel result; same packing as in_data.
- REQ-015: out_sat  output  CH  per-channel flag: result was clipped by saturation.

Function
- REQ-016: The FSM SHALL have three states: IDLE, ACC and OUT.
- REQ-017: in_ready SHALL be 1 in IDLE and ACC, and 0 in OUT; a beat is accepted when in_valid and in_ready are both 1.
- REQ-018: IDLE, accepted beat: acc[k] <= sign-extend(in_data[k]); cnt <= 0; latch len and act_en; go to OUT if len==0, else go to ACC.
- REQ-019: ACC, accepted beat: acc[k] <= acc[k] + sign-extend(in_data[k]); cnt <= cnt+1; go to OUT when cnt+1 == latched len.
- REQ-020: ACC with no accepted beat SHALL hold all state; gaps between beats are unlimited.
- REQ-021: out_valid SHALL be 1 exactly while in OUT, starting the cycle after the last beat is accepted (latency 1).
- REQ-022: In OUT, per channel: if the latched act_en==1 and acc<0, out_data = 0 and out_sat = 0.
- REQ-023: Otherwise, if acc > 2^(N-1)-1, out_data = 2^(N-1)-1 and out_sat = 1.
- REQ-024: Otherwise, if acc < -2^(N-1), out_data = -2^(N-1) and out_sat = 1.
- REQ-025: Otherwise out_data = acc[N-1:0] and out_sat = 0.
- REQ-026: Saturation and ReLU SHALL be applied independently per channel.
- REQ-027: out_data and out_sat SHALL be driven from registers, SHALL be stable for the whole OUT interval, and SHALL read 0 outside OUT.
- REQ-028: OUT with out_ready==1 SHALL go to IDLE next cycle; OUT with out_ready==0 SHALL hold (backpressure).
- REQ-029: There is no bypass from OUT to a new group; the earliest next acceptance is the cycle after OUT exits.
- REQ-030: The accumulator SHALL never overflow internally; ACC_W covers up to 2^LEN_W full-scale terms, including the extreme -2^(ACC_W-1).
- REQ-031: clear==1 SHALL force IDLE and zero acc, cnt, out_data and out_sat next edge, from any state; an in_valid beat in the same cycle is discarded.
- REQ-032: clear SHALL have priority over a beat acceptance or an out_ready handshake in the same cycle.
- REQ-033: in_data on non-accepted cycles SHALL be ignored.

Reset
- REQ-034: While rst_n==0: state IDLE, acc=0, cnt=0, latched len/act_en=0, out_valid=0, out_data=0, out_sat=0, applied immediately without waiting for clk.
- REQ-035: Reset asserted mid-group or mid-OUT SHALL discard the group; the first accepted beat after release starts a new group.

Verification (N=12, CH=4, LEN_W=4)
- REQ-036: len=2, act_en=0, ch0 beats 100, 200, -50 on consecutive cycles -> out_valid=1 one cycle after the third beat, ch0 out_data=250, out_sat[0]=0.
- REQ-037: len=1, act_en=1, ch1 beats -10, -20 and ch2 beats 300, 200 -> ch1=0, ch2=500, out_sat=0.
- REQ-038: len=15, 16 beats of 2047 on ch0 and of -2048 on ch3 -> ch0=2047, ch3=-2048, out_sat=4'b1001.
- REQ-039: Hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, in_valid beats ignored; out_ready=1 -> IDLE next cycle.
- REQ-040: len=3, clear asserted after 2 beats, then a new group with len=0 and ch0=7 -> out ch0=7, with no residue from the aborted group.
- REQ-041: rst_n pulsed low mid-OUT, between clock edges -> out_valid=0 and out_data=0 immediately; the next group computes correctly.
